channel_acq_responder: RTL and testbench
========================================

Name: channel_acq_responder

Overview:
- Channel-side end of the trigger/acquisition handshake driven by channel_acq_controller: the controller arms a channel with a trigger type on acq_enable, pulses acq_trig, and waits for acq_done.
- This block arms on acq_enable, runs a timed multi-waveform acquisition on acq_trig, and produces an AXI-Stream-style event record {type, event number}.
- It re-asserts acq_done after the record is accepted.
- Used as the per-channel acquisition sequencer and as the bench model of a channel FPGA.

Parameters:
- EVT_NUM_W, 24, event number width.
- LEN_W, 16, waveform length and gap counter width.

Ports:
- clk  in  1  TTC clock, 40 MHz.
- reset  in  1  synchronous, active-high.
- reset_event_num  in  1  synchronous clear of the event counter (TTC Channel B).
- acq_enable  in  2  arm and trigger type; 0 = disarmed, 1..3 = type.
- acq_trig  in  1  one-cycle trigger pulse.
- wfm_count  in  12  waveforms per event; 0 is treated as 1.
- wfm_len  in  LEN_W  cycles per waveform; 0 is treated as 1.
- wfm_gap  in  LEN_W  idle cycles between waveforms.
- acq_done  out  1  channel idle or finished.
- acq_busy  out  1  acquisition in progress.
- sample_valid  out  1  high on each acquired sample cycle.
- sample_idx  out  LEN_W  sample index within the current waveform.
- wfm_idx  out  12  current waveform index.
- evt_valid  out  1  event record valid.
- evt_ready  in  1  event record accepted.
- evt_data  out  32  {type[1:0], 6'b0, event_num[23:0]}.
- ignored_trig_count  out  16  triggers ignored; saturating.
- state  out  3  FSM state.

Behaviour:
- Reset values: acq_done=1; acq_busy, sample_valid, evt_valid = 0; sample_idx, wfm_idx, evt_data, ignored_trig_count, event_num = 0; state = IDLE. Reset applies mid-operation: acquisition aborted, no record emitted.
- FSM states:
  - IDLE (0): acq_done=1. acq_enable!=0 → ARMED; latch type.
  - ARMED (1): acq_done=1.
    - acq_enable==0 → IDLE.
    - acq_enable changes to another nonzero value → relatch type, stay.
    - acq_trig=1 → ACQUIRE.
  - On the trigger in ARMED:
    - Latch wfm_count, wfm_len, wfm_gap with zero substitution; later input changes do not affect this event.
    - event_num increments, wrapping 0xFFFFFF → 0, so the first event after reset is 1.
    - acq_done=0 and acq_busy=1 from the next cycle.
  - ACQUIRE (2): sample_valid=1; sample_idx counts 0..len-1.
    - On the last sample, wfm_idx increments.
    - If wfm_idx+1==count → REPORT.
    - Else if gap==0 → ACQUIRE, sample_idx=0, no dead cycle.
    - Else → GAP.
  - GAP (3): sample_valid=0; wait exactly gap cycles, then ACQUIRE.
  - REPORT (4): evt_valid=1, acq_busy=0, acq_done=0.
    - evt_data is stable while valid && !ready.
    - On evt_valid && evt_ready → WAIT_DISARM; evt_valid drops the next cycle.
  - WAIT_DISARM (5): acq_done=1. acq_enable==0 → IDLE.
- Timing: trigger sampled at edge T. ACQUIRE occupies count·len + (count−1)·gap cycles starting at T+1. evt_valid rises at T+1+that total.
- acq_enable deasserted during ACQUIRE, GAP or REPORT: ignored; the event completes normally.
- Ignored triggers: acq_trig in IDLE, ACQUIRE, GAP, REPORT or WAIT_DISARM increments ignored_trig_count, saturating at 0xFFFF, with no other effect.
- reset_event_num:
  - Clears event_num.
  - Coincident with an accepted trigger: event_num becomes 1.
  - During REPORT: the pending evt_data is unchanged.
- wfm_idx and sample_idx are cleared on entry to ACQUIRE from ARMED and held after completion.

Test Plan:
- Reset, acq_enable=2, acq_trig at T, count=3, len=4, gap=2 → sample_valid high on T+1..4, T+7..10, T+13..16; evt_valid at T+17 with evt_data=0x80000001; acq_done=1 one cycle after evt_ready.
- count=0, len=0, gap=5 → exactly one sample cycle at T+1; REPORT at T+2.
- evt_ready held 0 for 10 cycles → evt_valid and evt_data stable; acq_done stays 0 until the handshake.
- acq_trig pulses in IDLE, during ACQUIRE and in WAIT_DISARM → ignored_trig_count=3; event_num unchanged; output timing unaffected.
- Preload event_num=0xFFFFFF, then trigger → evt_data[23:0]=0; reset_event_num coincident with a trigger → record number 1.
- Assert reset in the middle of GAP → next cycle state=IDLE, acq_done=1, evt_valid=0; a new trigger then behaves as the first scenario.

Source files
------------

// File: rtl/channel_acq_responder.sv
// Channel-side acquisition sequencer: arms on acq_enable, runs a timed
// multi-waveform acquisition on acq_trig and hands out one event record.
module channel_acq_responder #(
    parameter int EVT_NUM_W = 24,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_event_num,
    input  logic [1:0]       acq_enable,
    input  logic             acq_trig,
    input  logic [11:0]      wfm_count,
    input  logic [LEN_W-1:0] wfm_len,
    input  logic [LEN_W-1:0] wfm_gap,
    output logic             acq_done,
    output logic             acq_busy,
    output logic             sample_valid,
    output logic [LEN_W-1:0] sample_idx,
    output logic [11:0]      wfm_idx,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [31:0]      evt_data,
    output logic [15:0]      ignored_trig_count,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ARMED       = 3'd1;
    localparam logic [2:0] S_ACQUIRE     = 3'd2;
    localparam logic [2:0] S_GAP         = 3'd3;
    localparam logic [2:0] S_REPORT      = 3'd4;
    localparam logic [2:0] S_WAIT_DISARM = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [1:0]           type_q, type_d;
    logic [11:0]          count_q, count_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     gap_q, gap_d;
    logic [LEN_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0]     sample_idx_q, sample_idx_d;
    logic [11:0]          wfm_idx_q, wfm_idx_d;
    logic [EVT_NUM_W-1:0] event_num_q, event_num_d;
    logic [31:0]          evt_data_q, evt_data_d;
    logic [15:0]          ign_q, ign_d;
    logic                 trig_ignored;

    // A counter clear coincident with a trigger must still number that event 1.
    logic [EVT_NUM_W-1:0] event_num_base, event_num_inc;
    assign event_num_base = reset_event_num ? '0 : event_num_q;
    assign event_num_inc  = event_num_base + EVT_NUM_W'(1);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        type_d       = type_q;
        count_d      = count_q;
        len_d        = len_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        sample_idx_d = sample_idx_q;
        wfm_idx_d    = wfm_idx_q;
        event_num_d  = event_num_base;
        evt_data_d   = evt_data_q;
        trig_ignored = 1'b0;

        case (state_q)
            S_IDLE: begin
                trig_ignored = acq_trig;
                if (acq_enable != 2'd0) begin
                    state_d = S_ARMED;
                    type_d  = acq_enable;
                end
            end
            S_ARMED: begin
                if (acq_enable == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    type_d = acq_enable;
                    if (acq_trig) begin
                        state_d      = S_ACQUIRE;
                        count_d      = (wfm_count == 12'd0) ? 12'd1 : wfm_count;
                        len_d        = (wfm_len == '0) ? LEN_W'(1) : wfm_len;
                        gap_d        = wfm_gap;
                        sample_idx_d = '0;
                        wfm_idx_d    = '0;
                        event_num_d  = event_num_inc;
                        evt_data_d   = {acq_enable, 30'(event_num_inc)};
                    end
                end
            end
            S_ACQUIRE: begin
                trig_ignored = acq_trig;
                if (sample_idx_q == len_q - LEN_W'(1)) begin
                    wfm_idx_d = wfm_idx_q + 12'd1;
                    if (wfm_idx_q + 12'd1 == count_q) begin
                        state_d = S_REPORT;
                    end else if (gap_q == '0) begin
                        sample_idx_d = '0;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_q - LEN_W'(1);
                    end
                end else begin
                    sample_idx_d = sample_idx_q + LEN_W'(1);
                end
            end
            S_GAP: begin
                trig_ignored = acq_trig;
                if (gap_cnt_q == '0) begin
                    state_d      = S_ACQUIRE;
                    sample_idx_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_W'(1);
                end
            end
            S_REPORT: begin
                trig_ignored = acq_trig;
                if (evt_ready) state_d = S_WAIT_DISARM;
            end
            S_WAIT_DISARM: begin
                trig_ignored = acq_trig;
                if (acq_enable == 2'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ign_d = (trig_ignored && ign_q != 16'hFFFF) ? ign_q + 16'd1 : ign_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            type_q       <= '0;
            count_q      <= '0;
            len_q        <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            sample_idx_q <= '0;
            wfm_idx_q    <= '0;
            event_num_q  <= '0;
            evt_data_q   <= '0;
            ign_q        <= '0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            count_q      <= count_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            sample_idx_q <= sample_idx_d;
            wfm_idx_q    <= wfm_idx_d;
            event_num_q  <= event_num_d;
            evt_data_q   <= evt_data_d;
            ign_q        <= ign_d;
        end
    end

    assign state              = state_q;
    assign acq_done           = (state_q == S_IDLE) || (state_q == S_ARMED) || (state_q == S_WAIT_DISARM);
    assign acq_busy           = (state_q == S_ACQUIRE) || (state_q == S_GAP);
    assign sample_valid       = (state_q == S_ACQUIRE);
    assign evt_valid          = (state_q == S_REPORT);
    assign sample_idx         = sample_idx_q;
    assign wfm_idx            = wfm_idx_q;
    assign evt_data           = evt_data_q;
    assign ignored_trig_count = ign_q;

endmodule

// File: tb/tb_channel_acq_responder.sv
// Self-checking bench for channel_acq_responder: table-driven scenarios,
// hand-written corner sequences and randomized events against an arithmetic model.
module tb_channel_acq_responder;

    localparam int EVT_NUM_W = 24;
    localparam int LEN_W     = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             reset_event_num = 1'b0;
    logic [1:0]       acq_enable = 2'd0;
    logic             acq_trig = 1'b0;
    logic [11:0]      wfm_count = 12'd0;
    logic [LEN_W-1:0] wfm_len = '0;
    logic [LEN_W-1:0] wfm_gap = '0;
    logic             acq_done, acq_busy, sample_valid, evt_valid;
    logic [LEN_W-1:0] sample_idx;
    logic [11:0]      wfm_idx;
    logic             evt_ready = 1'b0;
    logic [31:0]      evt_data;
    logic [15:0]      ignored_trig_count;
    logic [2:0]       state;

    channel_acq_responder #(.EVT_NUM_W(EVT_NUM_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .reset_event_num(reset_event_num),
        .acq_enable(acq_enable), .acq_trig(acq_trig),
        .wfm_count(wfm_count), .wfm_len(wfm_len), .wfm_gap(wfm_gap),
        .acq_done(acq_done), .acq_busy(acq_busy), .sample_valid(sample_valid),
        .sample_idx(sample_idx), .wfm_idx(wfm_idx), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_data(evt_data),
        .ignored_trig_count(ignored_trig_count), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: event counter and ignored-trigger counter.
    logic [23:0] model_num = 24'd0;
    int          model_ign = 0;

    typedef struct {
        logic [11:0] count;
        logic [15:0] len;
        logic [15:0] gap;
        logic [1:0]  typ;
        logic [1:0]  pre_typ;
        int          ready_delay;
        int          ign_k;
        bit          wd_trig;
        bit          drop_en;
        bit          clr_trig;
        bit          clr_rpt;
        int          exp_total;
        bit          use_exp;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input int count, input int len, input int gap, input int typ,
                                input int ready_delay, input int ign_k, input bit wd_trig,
                                input bit drop_en, input bit clr_trig, input bit clr_rpt,
                                input int exp_total, input bit use_exp, input logic [31:0] exp_data);
        vec_t v;
        v.count = 12'(count);  v.len = 16'(len);  v.gap = 16'(gap);
        v.typ = 2'(typ);       v.pre_typ = 2'd0;  v.ready_delay = ready_delay;
        v.ign_k = ign_k;       v.wd_trig = wd_trig; v.drop_en = drop_en;
        v.clr_trig = clr_trig; v.clr_rpt = clr_rpt; v.exp_total = exp_total;
        v.use_exp = use_exp;   v.exp_data = exp_data;
        return v;
    endfunction

    function automatic void bump_ign();
        model_ign = (model_ign == 65535) ? 65535 : model_ign + 1;
    endfunction

    // Runs one complete event starting from IDLE; all checks happen 1 time unit after a rising edge.
    task automatic run_event(input vec_t v);
        int c, l, g, total, period, p;
        logic [31:0] exp_data;
        c = (v.count == 12'd0) ? 1 : int'(v.count);
        l = (v.len == 16'd0) ? 1 : int'(v.len);
        g = int'(v.gap);
        period = l + g;
        total = (v.exp_total >= 0) ? v.exp_total : c * l + (c - 1) * g;

        if (v.pre_typ != 2'd0) begin
            acq_enable = v.pre_typ;
            @(posedge clk); #1;
            check("armed_pre_state", 32'(state), 32'd1);
        end
        acq_enable = v.typ;
        @(posedge clk); #1;
        check("armed_state", 32'(state), 32'd1);
        check("armed_done", 32'(acq_done), 32'd1);

        wfm_count = v.count; wfm_len = v.len; wfm_gap = v.gap;
        acq_trig = 1'b1; reset_event_num = v.clr_trig;
        @(posedge clk); #1;
        acq_trig = 1'b0; reset_event_num = 1'b0;
        wfm_count = 12'($urandom); wfm_len = 16'($urandom); wfm_gap = 16'($urandom);
        model_num = v.clr_trig ? 24'd1 : model_num + 24'd1;
        exp_data = v.use_exp ? v.exp_data : {v.typ, 6'b0, model_num};

        for (int k = 1; k <= total; k++) begin
            p = (k - 1) % period;
            check("sample_valid", 32'(sample_valid), 32'(p < l));
            if (p < l) begin
                check("sample_idx", 32'(sample_idx), 32'(p));
                check("wfm_idx", 32'(wfm_idx), 32'((k - 1) / period));
            end
            check("busy_in_acq", 32'(acq_busy), 32'd1);
            check("done_in_acq", 32'(acq_done), 32'd0);
            check("evt_valid_in_acq", 32'(evt_valid), 32'd0);
            if (k == v.ign_k) begin
                acq_trig = 1'b1;
                bump_ign();
            end
            if (v.drop_en && k == 1) acq_enable = 2'd0;
            @(posedge clk); #1;
            acq_trig = 1'b0;
        end

        check("evt_valid", 32'(evt_valid), 32'd1);
        check("evt_data", evt_data, exp_data);
        check("report_busy", 32'(acq_busy), 32'd0);
        check("report_done", 32'(acq_done), 32'd0);
        check("report_state", 32'(state), 32'd4);
        for (int d = 0; d < v.ready_delay; d++) begin
            if (v.clr_rpt && d == 0) reset_event_num = 1'b1;
            @(posedge clk); #1;
            reset_event_num = 1'b0;
            check("evt_valid_hold", 32'(evt_valid), 32'd1);
            check("evt_data_hold", evt_data, exp_data);
            check("done_hold", 32'(acq_done), 32'd0);
        end
        if (v.clr_rpt) model_num = 24'd0;

        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
        check("evt_valid_drop", 32'(evt_valid), 32'd0);
        check("done_after_accept", 32'(acq_done), 32'd1);
        check("wait_disarm_state", 32'(state), 32'd5);
        if (v.wd_trig) begin
            acq_trig = 1'b1;
            bump_ign();
            @(posedge clk); #1;
            acq_trig = 1'b0;
            check("wait_disarm_hold", 32'(state), 32'd5);
        end
        acq_enable = 2'd0;
        @(posedge clk); #1;
        check("idle_state", 32'(state), 32'd0);
        check("ignored_count", 32'(ignored_trig_count), 32'(model_ign));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t v;

        tbl[0] = mk(3, 4, 2, 2, 0, 0, 0, 0, 0, 0, 16, 1, 32'h8000_0001);
        tbl[1] = mk(0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h4000_0002);
        tbl[2] = mk(1, 3, 0, 3, 10, 0, 0, 0, 0, 0, 3, 1, 32'hC000_0003);
        tbl[3] = mk(2, 2, 0, 1, 0, 2, 1, 0, 0, 0, 4, 1, 32'h4000_0004);
        tbl[4] = mk(2, 3, 1, 2, 1, 0, 0, 1, 0, 0, 7, 1, 32'h8000_0005);
        tbl[5] = mk(4, 1, 3, 3, 2, 0, 0, 0, 0, 1, 13, 1, 32'hC000_0006);
        tbl[6] = mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 32'h4000_0001);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_done", 32'(acq_done), 32'd1);
        check("rst_busy", 32'(acq_busy), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_sample_idx", 32'(sample_idx), 32'd0);
        check("rst_wfm_idx", 32'(wfm_idx), 32'd0);
        check("rst_evt_data", evt_data, 32'd0);
        check("rst_ignored", 32'(ignored_trig_count), 32'd0);
        check("rst_state", 32'(state), 32'd0);

        // Trigger while IDLE is counted and otherwise ignored.
        acq_trig = 1'b1;
        @(posedge clk); #1;
        acq_trig = 1'b0;
        bump_ign();
        check("idle_trig_state", 32'(state), 32'd0);
        check("idle_trig_count", 32'(ignored_trig_count), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_event(tbl[i]);
            if (i == 3) check("ignored_three", 32'(ignored_trig_count), 32'd3);
        end

        // Event counter wrap: preload the counter to its maximum.
        force dut.event_num_q = 24'hFF_FFFF;
        @(posedge clk); #1;
        release dut.event_num_q;
        model_num = 24'hFF_FFFF;
        run_event(mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 32'h4000_0000));

        // Counter clear coincident with the trigger numbers the event 1.
        run_event(mk(2, 1, 1, 3, 0, 0, 0, 0, 1, 0, 3, 1, 32'hC000_0001));

        // Reset in the middle of GAP aborts the event with no record.
        acq_enable = 2'd2;
        @(posedge clk); #1;
        wfm_count = 12'd3; wfm_len = 16'd4; wfm_gap = 16'd2; acq_trig = 1'b1;
        @(posedge clk); #1;
        acq_trig = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("gap_before_reset", 32'(state), 32'd3);
        acq_enable = 2'd0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("gap_rst_state", 32'(state), 32'd0);
        check("gap_rst_done", 32'(acq_done), 32'd1);
        check("gap_rst_evt_valid", 32'(evt_valid), 32'd0);
        check("gap_rst_busy", 32'(acq_busy), 32'd0);
        check("gap_rst_evt_data", evt_data, 32'd0);
        model_num = 24'd0;
        model_ign = 0;
        run_event(tbl[0]);

        // Randomized events against the arithmetic model.
        for (int i = 0; i < 25; i++) begin
            v = mk(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                   int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 8)),
                   1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 32'd0);
            v.pre_typ  = 2'($urandom_range(0, 3));
            v.wd_trig  = 1'($urandom_range(0, 1));
            v.drop_en  = !v.wd_trig && ($urandom_range(0, 1) == 1);
            v.clr_trig = ($urandom_range(0, 7) == 0);
            v.clr_rpt  = (v.ready_delay > 0) && ($urandom_range(0, 5) == 0);
            run_event(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
